// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory stage: EX/MEM register, data memory, sized loads/stores
module mem_stage #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clrm,
  input  logic [31:0] instre,
  input  logic [31:0] pce,
  input  logic [31:0] aluoute,
  input  logic [31:0] writedatae,
  input  logic [4:0]  writerege,
  input  logic [31:0] pcplus8e,
  input  logic        frtm,
  input  logic [31:0] resultw,
  output logic [31:0] instrm,
  output logic [31:0] pcm,
  output logic [31:0] aluoutm,
  output logic [31:0] pcplus8m,
  output logic [4:0]  writeregm,
  output logic [31:0] readdatam,
  output logic        ades,
  output logic        adel
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  logic [31:0]   writedatam;
  logic [31:0]   mem [DEPTH];

  logic [5:0]    op;
  logic [AW-1:0] widx;
  logic [1:0]    off;
  logic [31:0]   rword;
  logic [31:0]   sdata;
  logic [31:0]   srep;
  logic [31:0]   wnew;
  logic [3:0]    be;
  logic [7:0]    lbyte;
  logic [15:0]   lhalf;

  assign op    = instrm[31:26];
  assign widx  = aluoutm[AW+1:2];
  assign off   = aluoutm[1:0];
  assign rword = mem[widx];
  assign sdata = frtm ? resultw : writedatam;

  // EX/MEM pipeline register; reset and flush both load a bubble
  always_ff @(posedge clk) begin
    if (!reset || clrm) begin
      instrm     <= '0;
      pcm        <= '0;
      aluoutm    <= '0;
      pcplus8m   <= '0;
      writedatam <= '0;
      writeregm  <= '0;
    end else begin
      instrm     <= instre;
      pcm        <= pce;
      aluoutm    <= aluoute;
      pcplus8m   <= pcplus8e;
      writedatam <= writedatae;
      writeregm  <= writerege;
    end
  end

  // Alignment faults and per-byte store enables; misaligned stores enable nothing
  always_comb begin
    ades = 1'b0;
    adel = 1'b0;
    be   = 4'b0000;
    srep = sdata;
    case (op)
      OP_SW: begin
        ades = (off != 2'b00);
        if (off == 2'b00) be = 4'b1111;
      end
      OP_SH: begin
        ades = off[0];
        srep = {2{sdata[15:0]}};
        if (!off[0]) be = off[1] ? 4'b1100 : 4'b0011;
      end
      OP_SB: begin
        srep = {4{sdata[7:0]}};
        be   = 4'b0001 << off;
      end
      OP_LW:         adel = (off != 2'b00);
      OP_LH, OP_LHU: adel = off[0];
      default: ;
    endcase
  end

  // Merge replicated store data into the current word under the byte enables
  always_comb begin
    wnew = rword;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) wnew[8*b +: 8] = srep[8*b +: 8];
    end
  end

  // Data memory: cleared on reset, otherwise one read-modify-write per store
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (be != 4'b0000) begin
      mem[widx] <= wnew;
    end
  end

  // Load path: pick the byte/halfword and extend; faults and non-loads read as 0
  always_comb begin
    case (off)
      2'd0:    lbyte = rword[7:0];
      2'd1:    lbyte = rword[15:8];
      2'd2:    lbyte = rword[23:16];
      default: lbyte = rword[31:24];
    endcase
    lhalf     = off[1] ? rword[31:16] : rword[15:0];
    readdatam = '0;
    if (!adel) begin
      case (op)
        OP_LW:  readdatam = rword;
        OP_LH:  readdatam = {{16{lhalf[15]}}, lhalf};
        OP_LHU: readdatam = {16'h0000, lhalf};
        OP_LB:  readdatam = {{24{lbyte[7]}}, lbyte};
        OP_LBU: readdatam = {24'h000000, lbyte};
        default: readdatam = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2b;

  logic        clk = 1'b0;
  logic        reset, clrm, frtm;
  logic [31:0] instre, pce, aluoute, writedatae, pcplus8e, resultw;
  logic [4:0]  writerege;
  logic [31:0] instrm, pcm, aluoutm, pcplus8m, readdatam;
  logic [4:0]  writeregm;
  logic        ades, adel;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_next = 32'h0040_0000;
  logic [31:0] last_pc;
  logic [31:0] last_instr;

  mem_stage dut (
    .clk(clk), .reset(reset), .clrm(clrm), .instre(instre), .pce(pce),
    .aluoute(aluoute), .writedatae(writedatae), .writerege(writerege),
    .pcplus8e(pcplus8e), .frtm(frtm), .resultw(resultw), .instrm(instrm),
    .pcm(pcm), .aluoutm(aluoutm), .pcplus8m(pcplus8m), .writeregm(writeregm),
    .readdatam(readdatam), .ades(ades), .adel(adel)
  );

  always #5 clk = ~clk;

  // Present one instruction in EX, clock it into M, sample 1ns after the edge
  task automatic issue(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd);
    instre     = {op, 5'd4, 5'd8, 16'h0abc};
    pce        = pc_next;
    pcplus8e   = pc_next + 32'd8;
    aluoute    = addr;
    writedatae = wd;
    writerege  = rd;
    last_pc    = pc_next;
    last_instr = instre;
    pc_next    = pc_next + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    issue(SW, 32'h14, 32'hDEADBEEF, 5'd0);
    issue(LW, 32'h14, 32'h0, 5'd3);
    checks++;
    if (readdatam !== 32'hDEADBEEF) begin
      errors++; $display("FAIL preload got %h want %h", readdatam, 32'hDEADBEEF);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({instrm, pcm, aluoutm, pcplus8m, writeregm} !== '0) begin
      errors++; $display("FAIL reset_regs got %h %h %h %h %h want 0",
                         instrm, pcm, aluoutm, pcplus8m, writeregm);
    end
    checks++;
    if ({readdatam, ades, adel} !== '0) begin
      errors++; $display("FAIL reset_outs got %h %b %b want 0", readdatam, ades, adel);
    end
    reset = 1'b1;
    issue(LW, 32'h14, 32'h0, 5'd3);
    checks++;
    if (readdatam !== 32'h0) begin
      errors++; $display("FAIL reset_mem got %h want 0", readdatam);
    end
  endtask

  task automatic test_partial_stores;
    issue(SW, 32'h20, 32'h11223344, 5'd0);
    issue(SB, 32'h21, 32'hFFFFFFAA, 5'd0);
    issue(SH, 32'h22, 32'h1234BBCC, 5'd0);
    issue(LW, 32'h20, 32'h0, 5'd9);
    checks++;
    if (readdatam !== 32'hBBCCAA44) begin
      errors++; $display("FAIL partial_store got %h want %h", readdatam, 32'hBBCCAA44);
    end
    checks++;
    if (writeregm !== 5'd9) begin
      errors++; $display("FAIL writeregm got %0d want 9", writeregm);
    end
  endtask

  task automatic test_load_ext;
    logic [5:0]  ops  [5] = '{LB, LBU, LH, LHU, LB};
    logic [31:0] adrs [5] = '{32'h42, 32'h42, 32'h42, 32'h40, 32'h40};
    logic [31:0] exps [5] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01, 32'h00000001};
    issue(SW, 32'h40, 32'h80FF7F01, 5'd0);
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], adrs[i], 32'h0, 5'd2);
      checks++;
      if (readdatam !== exps[i] || adel !== 1'b0) begin
        errors++; $display("FAIL load_ext[%0d] got %h adel %b want %h", i, readdatam, adel, exps[i]);
      end
    end
  endtask

  task automatic test_forwarding;
    issue(SW, 32'h60, 32'h1, 5'd0);
    checks++;
    if (aluoutm !== 32'h60 || pcplus8m !== last_pc + 32'd8 || pcm !== last_pc) begin
      errors++; $display("FAIL fwd_regs got %h %h %h want %h %h %h",
                         aluoutm, pcplus8m, pcm, 32'h60, last_pc + 32'd8, last_pc);
    end
    checks++;
    if (instrm !== last_instr) begin
      errors++; $display("FAIL instrm got %h want %h", instrm, last_instr);
    end
    frtm    = 1'b1;
    resultw = 32'h55;
    issue(LW, 32'h60, 32'h0, 5'd1);
    frtm    = 1'b0;
    resultw = 32'h0;
    checks++;
    if (readdatam !== 32'h55) begin
      errors++; $display("FAIL fwd_store got %h want %h", readdatam, 32'h55);
    end
  endtask

  task automatic test_misalign;
    issue(SW, 32'h22, 32'h99999999, 5'd0);
    checks++;
    if (ades !== 1'b1 || adel !== 1'b0) begin
      errors++; $display("FAIL ades got %b/%b want 1/0", ades, adel);
    end
    issue(LW, 32'h20, 32'h0, 5'd1);
    checks++;
    if (readdatam !== 32'hBBCCAA44 || ades !== 1'b0) begin
      errors++; $display("FAIL ades_nowrite got %h want %h", readdatam, 32'hBBCCAA44);
    end
    issue(LH, 32'h43, 32'h0, 5'd1);
    checks++;
    if (adel !== 1'b1 || readdatam !== 32'h0) begin
      errors++; $display("FAIL adel_lh got %b %h want 1 0", adel, readdatam);
    end
    issue(LB, 32'h43, 32'h0, 5'd1);
    checks++;
    if (adel !== 1'b0 || readdatam !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb_odd got %b %h want 0 ffffff80", adel, readdatam);
    end
    issue(LW, 32'h42, 32'h0, 5'd1);
    checks++;
    if (adel !== 1'b1 || readdatam !== 32'h0) begin
      errors++; $display("FAIL adel_lw got %b %h want 1 0", adel, readdatam);
    end
  endtask

  task automatic test_flush;
    clrm = 1'b1;
    issue(SW, 32'h80, 32'h99, 5'd7);
    clrm = 1'b0;
    checks++;
    if ({instrm, aluoutm, pcm, writeregm} !== '0) begin
      errors++; $display("FAIL flush_regs got %h %h %h %0d want 0", instrm, aluoutm, pcm, writeregm);
    end
    issue(LW, 32'h80, 32'h0, 5'd1);
    issue(LW, 32'h80, 32'h0, 5'd1);
    checks++;
    if (readdatam !== 32'h0) begin
      errors++; $display("FAIL flush_mem got %h want 0", readdatam);
    end
    issue(SW, 32'h84, 32'h77, 5'd0);
    reset = 1'b0;
    issue(LW, 32'h20, 32'h0, 5'd1);
    reset = 1'b1;
    checks++;
    if (instrm !== 32'h0 || aluoutm !== 32'h0) begin
      errors++; $display("FAIL midreset_regs got %h %h want 0", instrm, aluoutm);
    end
    issue(LW, 32'h84, 32'h0, 5'd1);
    checks++;
    if (readdatam !== 32'h0) begin
      errors++; $display("FAIL midreset_store got %h want 0", readdatam);
    end
    issue(LW, 32'h20, 32'h0, 5'd1);
    checks++;
    if (readdatam !== 32'h0) begin
      errors++; $display("FAIL midreset_mem got %h want 0", readdatam);
    end
  endtask

  initial begin
    reset = 1'b0; clrm = 1'b0; frtm = 1'b0; resultw = '0;
    instre = '0; pce = '0; aluoute = '0; writedatae = '0; pcplus8e = '0; writerege = '0;
    last_pc = '0; last_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    test_reset;
    test_partial_stores;
    test_load_ext;
    test_forwarding;
    test_misalign;
    test_flush;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the five-stage MIPS pipeline, directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and the data memory. Performs word, halfword and byte loads and stores, with sign or zero extension on loads.
- Returns aluoutm and pcplus8m to the execute stage for forwarding, and presents load data and register-file write information to writeback.

Parameters:
- DEPTH, 1024, data memory size in 32-bit words; must be a power of two.
- AW, 10, word-address width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- clrm  input  1  flush: load a bubble into EX/MEM this cycle.
- instre  input  32  instruction leaving EX.
- pce  input  32  PC of instre.
- aluoute  input  32  ALU or muldiv result / effective address from EX.
- writedatae  input  32  forwarded rt value from EX.
- writerege  input  5  destination register from EX.
- pcplus8e  input  32  pce+8 from EX.
- frtm  input  1  1 = replace store data with resultw (W-to-M forwarding).
- resultw  input  32  writeback-stage result.
- instrm  output  32  registered instruction.
- pcm  output  32  registered PC.
- aluoutm  output  32  registered ALU result (forwarding source).
- pcplus8m  output  32  registered pc+8 (forwarding source).
- writeregm  output  5  registered destination register.
- readdatam  output  32  extended load data (combinational from memory).
- ades  output  1  misaligned store flagged this cycle.
- adel  output  1  misaligned load flagged this cycle.

Behaviour:
- EX/MEM register
  - On a rising edge with reset=0: instrm, pcm, aluoutm, pcplus8m, writedatam (internal) and writeregm all become 0. Every memory word is also cleared to 0.
  - With reset=1 and clrm=1: all register fields load 0 (nop bubble). Memory is untouched.
  - Otherwise all fields capture their *e inputs. There is no stall input; stalls are inserted upstream.
- Decode from instrm[31:26]:
  - Loads: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25.
  - Stores: sb 0x28, sh 0x29, sw 0x2b.
  - Every other opcode is neither a load nor a store.
- Addressing
  - Word index = aluoutm[AW+1:2]; address bits above AW+1 are ignored (wrap).
  - Byte offset = aluoutm[1:0]. Little-endian: offset 0 is bits [7:0].
- Store data
  - sdata = resultw when frtm=1, otherwise writedatam.
- Store write (rising edge, reset=1)
  - sw: whole word written, only when offset==0.
  - sh: bytes {off+1, off} replaced with sdata[15:0], only when offset[0]==0.
  - sb: byte at offset replaced with sdata[7:0].
  - Unselected bytes keep their value. The write is visible to a load in the next cycle.
- Load (combinational)
  - lw returns the whole word.
  - lh/lhu select the halfword at offset[1]; lb/lbu select the byte at offset.
  - lh/lb sign-extend; lhu/lbu zero-extend.
  - Non-load instructions give readdatam = 0.
- Alignment
  - Misaligned sw/sh: the write is suppressed and ades=1.
  - Misaligned lw/lh/lhu: adel=1 and readdatam=0.
  - ades and adel are combinational from instrm/aluoutm and are 0 under reset values. No exception handling is performed here.
- Latency
  - One cycle from *e inputs to *m outputs.
  - readdatam is valid in the same cycle the instruction occupies M.

Test Plan:
- Reset: preload word 5 with 0xDEADBEEF, hold reset=0 one edge → all outputs 0; lw with address 0x14 then returns 0.
- Byte/half stores: sw 0x11223344 @0x20; sb 0xAA @0x21; sh 0xBBCC @0x22 → lw @0x20 returns 0xBBCCAA44.
- Load extension on word 0x80FF7F01 @0x40:
  - lb @0x42 → 0xFFFFFFFF; lbu @0x42 → 0x000000FF.
  - lh @0x42 → 0xFFFF80FF; lhu @0x40 → 0x00007F01; lb @0x40 → 0x00000001.
- Forwarding: sw with writedatae=0x1, resultw=0x55, frtm=1 → memory word = 0x55. aluoutm and pcplus8m equal the previous cycle's aluoute and pcplus8e.
- Misalignment: sw @0x22 → ades=1 and word unchanged. lh @0x43 → adel=1, readdatam=0.
- Flush: clrm=1 with an sw in EX → next cycle instrm=0, no memory write; reset asserted mid-stream clears both the pipeline register and memory.
